// File: rtl/router_ingress_ctrl.sv
// router_ingress_ctrl: ingress controller of the 1x3 router.
// Decodes the header byte and steers the packet to one of three output FIFOs.
// It stalls the source while the FIFO is busy and generates parity status.
// Ports:
//   clock, resetn            clock and synchronous active-low reset
//   pkt_valid, data_in       source byte stream (pkt_valid low on parity byte)
//   fifo_full, fifo_empty    status flags of FIFO 0..2
//   soft_reset               per-FIFO read-timeout reset
//   write_enb, dout          one-hot FIFO write enable and write data
//   lfd_state                pulses the cycle before the header write
//   busy                     source must hold data_in while high
//   parity_done, err         end-of-packet pulse and sticky error flag
// Optional feature: define ROUTER_PARITY_CHECK_EN to compare the packet parity.
module router_ingress_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [2:0]            fifo_full,
    input  logic [2:0]            fifo_empty,
    input  logic [2:0]            soft_reset,
    output logic [2:0]            write_enb,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  lfd_state,
    output logic                  busy,
    output logic                  parity_done,
    output logic                  err
);

    typedef enum logic [3:0] {
        S_DECODE,
        S_WAIT,
        S_FIRST,
        S_HDR,
        S_LOAD,
        S_FULL,
        S_AFTER_FULL,
        S_CHECK,
        S_DROP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] header_q, header_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  is_par_q, is_par_d;
    logic                  err_q, err_d;
    logic                  pdone_q, pdone_d;
`ifdef ROUTER_PARITY_CHECK_EN
    logic [DATA_WIDTH-1:0] par_q, par_d;
    logic [DATA_WIDTH-1:0] rx_par_q, rx_par_d;
`endif

    function automatic logic [2:0] addr_oh(input logic [1:0] a);
        logic [2:0] r;
        r = 3'b000;
        case (a)
            2'd0:    r = 3'b001;
            2'd1:    r = 3'b010;
            2'd2:    r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    logic [2:0] sel_oh;
    logic [2:0] hdr_oh;
    logic       sel_full;
    logic       sel_empty;
    logic       hdr_empty;
    logic       accept;
    logic       abort;
    logic       wr;

    assign sel_oh    = addr_oh(header_q[1:0]);
    assign hdr_oh    = addr_oh(data_in[1:0]);
    assign sel_full  = |(fifo_full & sel_oh);
    assign sel_empty = |(fifo_empty & sel_oh);
    assign hdr_empty = |(fifo_empty & hdr_oh);
    assign accept    = (state_q == S_DECODE) && pkt_valid
                       && (data_in[1:0] != 2'b11);
    // Soft reset of the selected FIFO aborts the packet in flight.
    assign abort     = (state_q inside {S_WAIT, S_FIRST, S_HDR, S_LOAD,
                                        S_FULL, S_AFTER_FULL})
                       && |(soft_reset & sel_oh);

    // State register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= S_DECODE;
            header_q <= '0;
            hold_q   <= '0;
            is_par_q <= 1'b0;
            err_q    <= 1'b0;
            pdone_q  <= 1'b0;
`ifdef ROUTER_PARITY_CHECK_EN
            par_q    <= '0;
            rx_par_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            header_q <= header_d;
            hold_q   <= hold_d;
            is_par_q <= is_par_d;
            err_q    <= err_d;
            pdone_q  <= pdone_d;
`ifdef ROUTER_PARITY_CHECK_EN
            par_q    <= par_d;
            rx_par_q <= rx_par_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_DECODE:     if (accept)
                              state_d = hdr_empty ? S_FIRST : S_WAIT;
            S_WAIT:       if (sel_empty) state_d = S_FIRST;
            S_FIRST:      state_d = S_HDR;
            S_HDR:        state_d = S_LOAD;
            S_LOAD:       if (sel_full) state_d = S_FULL;
                          else if (!pkt_valid) state_d = S_CHECK;
            S_FULL:       if (!sel_full) state_d = S_AFTER_FULL;
            S_AFTER_FULL: state_d = is_par_q ? S_CHECK : S_LOAD;
            S_CHECK:      state_d = S_DECODE;
            S_DROP:       if (!pkt_valid) state_d = S_DECODE;
            default:      state_d = S_DECODE;
        endcase
        if (abort) state_d = pkt_valid ? S_DROP : S_DECODE;
    end

    // Datapath registers
    always_comb begin
        header_d = header_q;
        hold_d   = hold_q;
        is_par_d = is_par_q;
        err_d    = err_q;
        pdone_d  = 1'b0;
`ifdef ROUTER_PARITY_CHECK_EN
        par_d    = par_q;
        rx_par_d = rx_par_q;
`endif
        case (state_q)
            S_DECODE: if (accept) begin
                header_d = data_in;
                err_d    = 1'b0;
`ifdef ROUTER_PARITY_CHECK_EN
                par_d    = data_in;
`endif
            end
            S_LOAD: begin
                if (sel_full) begin
                    hold_d   = data_in;
                    is_par_d = !pkt_valid;
                end
`ifdef ROUTER_PARITY_CHECK_EN
                else if (pkt_valid) par_d = par_q ^ data_in;
                else rx_par_d = data_in;
`endif
            end
`ifdef ROUTER_PARITY_CHECK_EN
            S_AFTER_FULL: begin
                if (is_par_q) rx_par_d = hold_q;
                else par_d = par_q ^ hold_q;
            end
`endif
            S_CHECK: begin
                pdone_d = 1'b1;
`ifdef ROUTER_PARITY_CHECK_EN
                err_d   = (par_q != rx_par_q);
`else
                err_d   = err_q;
`endif
            end
            S_DROP: if (!pkt_valid) begin
                err_d   = 1'b1;
                pdone_d = 1'b1;
            end
            default: ;
        endcase
        if (abort && !pkt_valid) begin
            err_d   = 1'b1;
            pdone_d = 1'b1;
        end
    end

    // Outputs; writes are also blocked while resetn is low
    always_comb begin
        wr = 1'b0;
        case (state_q)
            S_HDR:        wr = 1'b1;
            S_LOAD:       wr = !sel_full;
            S_AFTER_FULL: wr = 1'b1;
            default:      wr = 1'b0;
        endcase
        if (abort || !resetn) wr = 1'b0;
        write_enb = wr ? sel_oh : 3'b000;
        dout      = '0;
        if (wr) begin
            case (state_q)
                S_HDR:        dout = header_q;
                S_AFTER_FULL: dout = hold_q;
                default:      dout = data_in;
            endcase
        end
        lfd_state = (state_q == S_FIRST);
        busy      = state_q inside {S_WAIT, S_FIRST, S_HDR, S_FULL,
                                    S_AFTER_FULL, S_CHECK};
    end

    assign parity_done = pdone_q;
    assign err         = err_q;

endmodule
